store_arbiter: RTL
==================

# store_arbiter

Sequencing controller and arbiter for the 32 x 32-bit Store Lines RAM. It grants one of three requesters per transaction: the CPU (read/write), the manual loader (write-only typewriter/KSP path) and the CRT display refresh scanner (read-only, auto-incrementing). It generates correctly ordered CS_n/WE_n/OE_n strobes with programmable setup, pulse and hold lengths, since the store is asynchronous.

## Interface
- SETUP_CYCLES, 1: cycles CS_n low with address/data valid before a strobe (>=1)
- WRITE_CYCLES, 6: WE_n low width (>=1)
- READ_CYCLES, 6: OE_n low width; Q sampled on last cycle (>=1)
- HOLD_CYCLES, 1: cycles CS_n low after strobe release (>=1)
- MAX_STARVE, 4: consecutive CPU/loader grants allowed while display is pending (>=1)

Ports:
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request (level)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  5  CPU store line
- cpu_wdata  in  32  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data, valid from ack cycle until next CPU read ack
- ld_req  in  1  loader write request (level)
- ld_addr  in  5  loader store line
- ld_wdata  in  32  loader write data
- ld_ack  out  1  one-cycle completion pulse
- disp_en  in  1  enable display refresh scanning
- disp_valid  out  1  one-cycle pulse: disp_line/disp_data valid
- disp_line  out  5  line just read
- disp_data  out  32  contents of disp_line
- store_a  out  5  to store A
- store_d  out  32  to store D
- store_q  in  32  from store Q
- store_cs_n, store_we_n, store_oe_n  out  1 each  store strobes

## Operation
- FSM states: IDLE, SETUP, WRITE, READ, HOLD.
- IDLE: strobes all high. On a clock edge with any request, the winner is chosen, its address/data/direction are registered into store_a/store_d, and the FSM enters SETUP. With no request it stays in IDLE.
- Priority is CPU > loader > display.
- Override: if the starvation count equals MAX_STARVE and the display is pending, the display wins.
- Display is pending whenever disp_en=1.
- Starvation count:
  - increments on each CPU/loader grant while the display is pending;
  - clears on a display grant or when disp_en=0;
  - saturates at MAX_STARVE.
- SETUP: CS_n=0, WE_n=1, OE_n=1. Next state is WRITE or READ.
- WRITE: CS_n=0, WE_n=0.
- READ: CS_n=0, OE_n=0. store_q is captured into the winner's read register on the final READ cycle.
- HOLD: CS_n=0, WE_n=1, OE_n=1. The winner's ack or disp_valid is high during the final HOLD cycle, then the FSM returns to IDLE.
- store_a/store_d are held constant from SETUP through HOLD.
- WE_n and OE_n are never low together. CS_n is high in IDLE.
- Requesters hold req and operands until ack. The request drops on the edge ending the ack cycle. A req still high in IDLE is a new request.
- Display scanner:
  - reads line disp_line_ptr;
  - on completion, presents disp_line=pointer and disp_data=captured Q, then increments the pointer mod 32 (31 wraps to 0);
  - disp_en=0 holds the pointer; an in-flight display read still completes and pulses disp_valid.
- Reset (asynchronous):
  - state IDLE; all strobes 1;
  - store_a, store_d, cpu_rdata, disp_data, disp_line, pointer and starvation count = 0;
  - all acks and disp_valid = 0.
  - Reset mid-transaction aborts immediately with no ack. Store contents at that address are undefined after an aborted write.

## Timing
- A grant occurs on edge k in IDLE. SETUP, strobe and HOLD then occupy S + W (or R) + H cycles.
- The ack is high in the last of these cycles, and IDLE lasts at least 1 cycle.
- Defaults: write and read each take 8 cycles from grant to ack. Back-to-back throughput is 9 cycles per transaction.
- Request to ack latency is 1 + S + W/R + H cycles when the requester wins immediately.
- A request arriving during a transaction waits; arbitration happens only in IDLE.
- Simultaneous requests in the same IDLE cycle are resolved by priority/starvation in that cycle. There is no queueing beyond each level req.

## Test plan
- Reset then CPU write 0xDEADBEEF to line 0 and CPU read line 0 → strobe order CS_n↓, WE_n↓ for 6 cycles, WE_n↑, CS_n↑. cpu_ack after 8 cycles; cpu_rdata=0xDEADBEEF. OE_n and WE_n are never both low.
- Simultaneous cpu_req and ld_req (line 0x1F, 0x0F0F0F0F) → CPU granted first. The loader is granted in the next IDLE and line 31 reads back 0x0F0F0F0F.
- disp_en=1 with no other traffic → disp_line sequence 0,1,…,31,0 with a disp_valid pulse every 9 cycles. disp_data matches preloaded contents.
- CPU requests continuously with disp_en=1 → exactly one display grant after every 4 CPU grants. The CPU is never blocked for more than one transaction.
- disp_en cleared mid-read of line 5 → disp_valid still pulses for line 5 and the pointer holds at 6. The starvation count clears.
- reset_n asserted during WRITE → strobes go high immediately and no ack is issued. After release the FSM is in IDLE and a subsequent CPU read completes normally.

Source files
------------

// File: rtl/store_arbiter_if.sv
`timescale 1ns/1ps
// store_arbiter_if
// Bundles the three requester ports (CPU, manual loader, display scanner)
// and the asynchronous Store Lines RAM pins into one interface.
//   slave  : arbiter view (takes requests, drives acks and store strobes)
//   master : requester / store-model view (drives requests and store Q)
interface store_arbiter_if;
  // CPU port
  logic        cpu_req;
  logic        cpu_we;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  // manual loader port (write only)
  logic        ld_req;
  logic [4:0]  ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_ack;
  // display refresh scanner
  logic        disp_en;
  logic        disp_valid;
  logic [4:0]  disp_line;
  logic [31:0] disp_data;
  // store pins
  logic [4:0]  store_a;
  logic [31:0] store_d;
  logic [31:0] store_q;
  logic        store_cs_n;
  logic        store_we_n;
  logic        store_oe_n;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  ld_req, ld_addr, ld_wdata,
    output ld_ack,
    input  disp_en,
    output disp_valid, disp_line, disp_data,
    output store_a, store_d, store_cs_n, store_we_n, store_oe_n,
    input  store_q
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output ld_req, ld_addr, ld_wdata,
    input  ld_ack,
    output disp_en,
    input  disp_valid, disp_line, disp_data,
    input  store_a, store_d, store_cs_n, store_we_n, store_oe_n,
    output store_q
  );
endinterface

// File: rtl/store_arbiter.sv
`timescale 1ns/1ps
// store_arbiter
// Arbitrates one transaction at a time between the CPU (read/write), the
// manual loader (write) and the display refresh scanner (read, auto-
// incrementing line pointer) onto the 32 x 32-bit asynchronous Store Lines
// RAM, sequencing CS_n/WE_n/OE_n with programmable setup/pulse/hold lengths.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      store_arbiter_if.slave (requester handshakes + store pins)
//
// state | meaning
// IDLE  | strobes high; arbitrate and latch winner's address/data
// SETUP | CS_n low, address/data settling before the strobe
// WRITE | CS_n and WE_n low
// READ  | CS_n and OE_n low; Q captured on last cycle
// HOLD  | CS_n low, strobes released; ack/disp_valid on last cycle
module store_arbiter #(
  parameter int SETUP_CYCLES = 1,
  parameter int WRITE_CYCLES = 6,
  parameter int READ_CYCLES  = 6,
  parameter int HOLD_CYCLES  = 1,
  parameter int MAX_STARVE   = 4
) (
  input logic            clk,
  input logic            reset_n,
  store_arbiter_if.slave bus
);

  localparam int MAX_WR    = (WRITE_CYCLES > READ_CYCLES) ? WRITE_CYCLES : READ_CYCLES;
  localparam int MAX_SH    = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_PHASE = (MAX_WR > MAX_SH) ? MAX_WR : MAX_SH;
  localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
  localparam int STV_W     = $clog2(MAX_STARVE + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_WRITE, ST_READ, ST_HOLD
  } state_t;

  typedef enum logic [1:0] {
    OWN_CPU, OWN_LD, OWN_DISP
  } owner_t;

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [4:0]       store_a_q, store_a_d;
  logic [31:0]      store_d_q, store_d_d;
  logic             cs_n_q, cs_n_d;
  logic             we_n_q, we_n_d;
  logic             oe_n_q, oe_n_d;
  logic             cpu_ack_q, cpu_ack_d;
  logic             ld_ack_q, ld_ack_d;
  logic             disp_valid_q, disp_valid_d;
  logic [31:0]      cpu_rdata_q, cpu_rdata_d;
  logic [31:0]      disp_data_q, disp_data_d;
  logic [4:0]       disp_line_q, disp_line_d;
  logic [4:0]       ptr_q, ptr_d;
  logic [STV_W-1:0] starve_q, starve_d;

  logic last_cnt;
  logic disp_win;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    store_a_d    = store_a_q;
    store_d_d    = store_d_q;
    cpu_rdata_d  = cpu_rdata_q;
    disp_data_d  = disp_data_q;
    disp_line_d  = disp_line_q;
    ptr_d        = ptr_q;
    starve_d     = starve_q;
    cpu_ack_d    = 1'b0;
    ld_ack_d     = 1'b0;
    disp_valid_d = 1'b0;

    last_cnt = (cnt_q == '0);
    // Display wins when nobody else asks, or when it has been passed over
    // MAX_STARVE times in a row.
    disp_win = bus.disp_en &&
               ((starve_q == STV_W'(MAX_STARVE)) || !(bus.cpu_req || bus.ld_req));

    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req || bus.ld_req || bus.disp_en) begin
          state_d = ST_SETUP;
          cnt_d   = CNT_W'(SETUP_CYCLES - 1);
          if (disp_win) begin
            owner_d   = OWN_DISP;
            wr_d      = 1'b0;
            store_a_d = ptr_q;
            starve_d  = '0;
          end else begin
            if (bus.cpu_req) begin
              owner_d   = OWN_CPU;
              wr_d      = bus.cpu_we;
              store_a_d = bus.cpu_addr;
              store_d_d = bus.cpu_wdata;
            end else begin
              owner_d   = OWN_LD;
              wr_d      = 1'b1;
              store_a_d = bus.ld_addr;
              store_d_d = bus.ld_wdata;
            end
            if (starve_q != STV_W'(MAX_STARVE)) begin
              starve_d = starve_q + 1'b1;
            end
          end
        end
      end
      ST_SETUP: begin
        if (last_cnt) begin
          state_d = wr_q ? ST_WRITE : ST_READ;
          cnt_d   = wr_q ? CNT_W'(WRITE_CYCLES - 1) : CNT_W'(READ_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WRITE: begin
        if (last_cnt) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_READ: begin
        if (last_cnt) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          if (owner_q == OWN_CPU) begin
            cpu_rdata_d = bus.store_q;
          end else if (owner_q == OWN_DISP) begin
            disp_data_d = bus.store_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (last_cnt) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A disabled display is not pending, so nothing is being starved.
    if (!bus.disp_en) begin
      starve_d = '0;
    end

    // Strobes and completion pulses are registered from the next state so
    // they line up exactly with the state they describe.
    cs_n_d = (state_d == ST_IDLE);
    we_n_d = (state_d != ST_WRITE);
    oe_n_d = (state_d != ST_READ);

    if ((state_d == ST_HOLD) && (cnt_d == '0) &&
        !((state_q == ST_HOLD) && (cnt_q == '0))) begin
      case (owner_d)
        OWN_CPU: cpu_ack_d = 1'b1;
        OWN_LD:  ld_ack_d  = 1'b1;
        default: begin
          disp_valid_d = 1'b1;
          disp_line_d  = ptr_q;
          ptr_d        = ptr_q + 5'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CPU;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      store_a_q    <= '0;
      store_d_q    <= '0;
      cs_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      cpu_ack_q    <= 1'b0;
      ld_ack_q     <= 1'b0;
      disp_valid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      disp_data_q  <= '0;
      disp_line_q  <= '0;
      ptr_q        <= '0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      store_a_q    <= store_a_d;
      store_d_q    <= store_d_d;
      cs_n_q       <= cs_n_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      cpu_ack_q    <= cpu_ack_d;
      ld_ack_q     <= ld_ack_d;
      disp_valid_q <= disp_valid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      disp_data_q  <= disp_data_d;
      disp_line_q  <= disp_line_d;
      ptr_q        <= ptr_d;
      starve_q     <= starve_d;
    end
  end

  assign bus.store_a    = store_a_q;
  assign bus.store_d    = store_d_q;
  assign bus.store_cs_n = cs_n_q;
  assign bus.store_we_n = we_n_q;
  assign bus.store_oe_n = oe_n_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.ld_ack     = ld_ack_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_line  = disp_line_q;
  assign bus.disp_data  = disp_data_q;

endmodule
